// File: rtl/conv_kxk_mch_seq.sv
// Sequential KxK, multi-channel convolution: one window per handshake, one tap per cycle.
// Optional macro CONV_SATURATE_EN clamps each channel result instead of wrapping it.
module conv_kxk_mch_seq #(
    parameter int PIX_W  = 8,
    parameter int WGT_W  = 8,
    parameter int KSIZE  = 3,
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 16,
    localparam int TAPS  = KSIZE * KSIZE,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAPS*PIX_W-1:0]    pixels_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*ACC_W-1:0]  result_out,
    input  logic                     wt_we,
    input  logic [CH_W-1:0]          wt_ch,
    input  logic [TAP_W-1:0]         wt_tap,
    input  logic [WGT_W-1:0]         wt_data,
    output logic                     busy
);
    localparam int PROD_W = PIX_W + WGT_W;
    localparam int SUM_W  = PIX_W + WGT_W + $clog2(TAPS);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t             state_reg, state_next;
    logic [TAP_W-1:0]   k_reg;
    logic [PIX_W-1:0]   pix_reg [TAPS];
    logic [PIX_W-1:0]   pix_tap;
    logic               accept;
    logic               last_tap;
    logic               wt_write;

    assign accept   = (state_reg == IDLE) && in_valid;
    assign last_tap = (k_reg == TAP_W'(TAPS - 1));
    assign wt_write = (state_reg == IDLE) && wt_we && (32'(wt_tap) < TAPS);
    assign pix_tap  = pix_reg[k_reg];

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == OUT);
    assign busy      = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = ACC;
            ACC:     if (last_tap)  state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept)
                k_reg <= '0;
            else if (state_reg == ACC)
                k_reg <= k_reg + TAP_W'(1);
        end
    end

    // Window is captured once at accept so upstream may move on immediately.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int t = 0; t < TAPS; t++)
                pix_reg[t] <= pixels_in[t*PIX_W +: PIX_W];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [WGT_W-1:0]  weight_reg [TAPS];
            logic [SUM_W-1:0]  acc_reg;
            logic [PROD_W-1:0] prod;

            // A write landing on the accept edge is visible from the first tap onward.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int t = 0; t < TAPS; t++)
                        weight_reg[t] <= WGT_W'(gi + t + 2);
                end else if (wt_write && (wt_ch == CH_W'(gi))) begin
                    weight_reg[wt_tap] <= wt_data;
                end
            end

            assign prod = PROD_W'(pix_tap) * PROD_W'(weight_reg[k_reg]);

            always_ff @(posedge clk) begin
                if (!rst_n || accept)
                    acc_reg <= '0;
                else if (state_reg == ACC)
                    acc_reg <= acc_reg + SUM_W'(prod);
            end

            if (SUM_W > ACC_W) begin : g_reduce
`ifdef CONV_SATURATE_EN
                assign result_out[gi*ACC_W +: ACC_W] =
                    (|acc_reg[SUM_W-1:ACC_W]) ? {ACC_W{1'b1}} : acc_reg[ACC_W-1:0];
`else
                assign result_out[gi*ACC_W +: ACC_W] = acc_reg[ACC_W-1:0];
`endif
            end else begin : g_extend
                assign result_out[gi*ACC_W +: ACC_W] = ACC_W'(acc_reg);
            end
        end
    endgenerate

endmodule

// File: tb/tb_conv_kxk_mch_seq.sv
// Scoreboard bench for conv_kxk_mch_seq: expected sums queued at accept, compared at output handshake.
module tb_conv_kxk_mch_seq;
    localparam int PIX_W  = 8;
    localparam int WGT_W  = 8;
    localparam int KSIZE  = 3;
    localparam int NUM_CH = 4;
    localparam int ACC_W  = 16;
    localparam int TAPS   = KSIZE * KSIZE;
    localparam int RES_W  = NUM_CH * ACC_W;
    localparam int WIN_W  = TAPS * PIX_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIN_W-1:0] pixels_in;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] result_out;
    logic             wt_we;
    logic [1:0]       wt_ch;
    logic [3:0]       wt_tap;
    logic [WGT_W-1:0] wt_data;
    logic             busy;

    conv_kxk_mch_seq #(
        .PIX_W(PIX_W), .WGT_W(WGT_W), .KSIZE(KSIZE), .NUM_CH(NUM_CH), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .pixels_in(pixels_in),
        .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out),
        .wt_we(wt_we), .wt_ch(wt_ch), .wt_tap(wt_tap), .wt_data(wt_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int               vec_count = 0;
    int               err_count = 0;
    int               cyc = 0;
    int               last_accept_edge = 0;
    logic [RES_W-1:0] exp_q [$];
    int               model_w [NUM_CH][TAPS];
    logic             prev_out_valid = 1'b0;
    logic             hs_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vec_count++;
        if (observed !== expected) begin
            err_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int t = 0; t < TAPS; t++)
                model_w[c][t] = (c + t + 2) & ((1 << WGT_W) - 1);
    endfunction

    function automatic logic [RES_W-1:0] model_result(input logic [WIN_W-1:0] pix);
        logic [RES_W-1:0] r;
        longint s;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            s = 0;
            for (int t = 0; t < TAPS; t++)
                s += longint'(pix[t*PIX_W +: PIX_W]) * longint'(model_w[c][t]);
`ifdef CONV_SATURATE_EN
            if (s > (longint'(1) << ACC_W) - 1)
                s = (longint'(1) << ACC_W) - 1;
`endif
            r[c*ACC_W +: ACC_W] = s[ACC_W-1:0];
        end
        return r;
    endfunction

    // Output monitor: latency at rising out_valid, single-cycle valid after handshake, scoreboard pop.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_out_valid <= 1'b0;
            hs_prev        <= 1'b0;
        end else begin
            if (hs_prev)
                check_eq("valid_drops_after_hs", out_valid, 1'b0);
            if (out_valid && !prev_out_valid)
                check_eq("latency", cyc - last_accept_edge, TAPS);
            if (out_valid && out_ready) begin
                check_eq("queue_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    logic [RES_W-1:0] e;
                    e = exp_q.pop_front();
                    check_eq("result", result_out, e);
                    $display("result 0x%016h expected 0x%016h at cycle %0d", result_out, e, cyc);
                end
            end
            hs_prev        <= out_valid && out_ready;
            prev_out_valid <= out_valid;
        end
    end

    task automatic send_window(input logic [WIN_W-1:0] pix, input bit wr,
                               input int wch, input int wtap, input int wdata,
                               output int accept_edge);
        int waited;
        waited = 0;
        accept_edge = -1;
        @(posedge clk); #1;
        pixels_in = pix;
        in_valid  = 1'b1;
        if (wr) begin
            wt_we   = 1'b1;
            wt_ch   = 2'(wch);
            wt_tap  = 4'(wtap);
            wt_data = 8'(wdata);
        end
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", in_ready, 1'b1);
        end else begin
            if (wr && wch < NUM_CH && wtap < TAPS)
                model_w[wch][wtap] = wdata;
            exp_q.push_back(model_result(pix));
            last_accept_edge = cyc + 1;
            accept_edge      = cyc + 1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wt_we    = 1'b0;
        for (int t = 0; t < TAPS; t++)
            pixels_in[t*PIX_W +: PIX_W] = 8'($urandom);
    endtask

    task automatic write_wt(input int ch, input int tap, input int data);
        @(posedge clk); #1;
        wt_we   = 1'b1;
        wt_ch   = 2'(ch);
        wt_tap  = 4'(tap);
        wt_data = 8'(data);
        @(posedge clk); #1;
        wt_we = 1'b0;
        if (ch < NUM_CH && tap < TAPS)
            model_w[ch][tap] = data;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        check_eq("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    function automatic logic [WIN_W-1:0] rand_window();
        logic [WIN_W-1:0] v;
        for (int t = 0; t < TAPS; t++)
            v[t*PIX_W +: PIX_W] = 8'($urandom);
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIN_W-1:0] ones, all_ff, w1, w2;
        logic [RES_W-1:0] hold_res;
        int               ae, a2, hs_edge, waited;
        logic             seen_valid;

        for (int t = 0; t < TAPS; t++)
            ones[t*PIX_W +: PIX_W] = 8'd1;
        all_ff = '1;

        rst_n = 1'b0; in_valid = 1'b0; pixels_in = '0; out_ready = 1'b0;
        wt_we = 1'b0; wt_ch = '0; wt_tap = '0; wt_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_result", result_out, '0);
        check_eq("model_ones_golden", model_result(ones), 64'h0051_0048_003F_0036);

        out_ready = 1'b1;
        send_window(ones, 1'b0, 0, 0, 0, ae);
        @(negedge clk);
        check_eq("busy_in_acc", busy, 1'b1);
        check_eq("in_ready_in_acc", in_ready, 1'b0);
        wait_drain();

        send_window(all_ff, 1'b0, 0, 0, 0, ae);
        wait_drain();

        for (int i = 0; i < 3; i++) begin
            send_window(rand_window(), 1'b0, 0, 0, 0, ae);
            wait_drain();
        end

        // ch0 weights all 255 with full-scale pixels: clamp or wrap depending on build.
        for (int t = 0; t < TAPS; t++)
            write_wt(0, t, 255);
        send_window(all_ff, 1'b0, 0, 0, 0, ae);
        wait_drain();

        // Reset at the fourth ACC cycle aborts the window and reloads default weights.
        send_window(ones, 1'b0, 0, 0, 0, ae);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_out_valid", out_valid, 1'b0);
        seen_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        check_eq("abort_no_valid", seen_valid, 1'b0);
        send_window(ones, 1'b0, 0, 0, 0, ae);
        wait_drain();

        // Weight write during ACC is ignored for this and the next window.
        send_window(ones, 1'b0, 0, 0, 0, ae);
        @(posedge clk); #1;
        wt_we = 1'b1; wt_ch = 2'd1; wt_tap = 4'd0; wt_data = 8'd0;
        @(posedge clk); #1;
        wt_we = 1'b0;
        wait_drain();
        send_window(ones, 1'b0, 0, 0, 0, ae);
        wait_drain();

        // Backpressure: result held, second window waits for handshake plus one IDLE cycle.
        out_ready = 1'b0;
        w1 = rand_window();
        w2 = rand_window();
        a2 = -1;
        hs_edge = -100;
        fork
            begin
                send_window(w1, 1'b0, 0, 0, 0, ae);
                send_window(w2, 1'b0, 0, 0, 0, a2);
            end
            begin
                waited = 0;
                @(negedge clk);
                while (!out_valid && waited < 100) begin
                    @(negedge clk);
                    waited++;
                end
                check_eq("bp_valid_seen", out_valid, 1'b1);
                hold_res = result_out;
                repeat (5) begin
                    @(negedge clk);
                    check_eq("bp_result_stable", result_out, hold_res);
                    check_eq("bp_valid_held", out_valid, 1'b1);
                    check_eq("bp_in_ready_low", in_ready, 1'b0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
                @(negedge clk);
                hs_edge = cyc + 1;
            end
        join
        check_eq("bp_second_accept_edge", a2, hs_edge + 1);
        wait_drain();

        // Weight write coinciding with accept is used by that window.
        send_window(rand_window(), 1'b1, 2, 4, 100, ae);
        wait_drain();

        // Out-of-range tap index has no effect.
        write_wt(3, 12, 0);
        send_window(all_ff, 1'b0, 0, 0, 0, ae);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule

// File: doc/conv_kxk_mch_seq.md
# conv_kxk_mch_seq

Parametrised, sequential successor to the team's fixed 3x3/4-channel combinational convolution. Accepts one packed KxK pixel window per valid/ready handshake and multiply-accumulates it against NUM_CH runtime-loadable weight kernels, one tap per cycle. Presents the packed per-channel sums on a valid/ready output held under backpressure. Sits between the line-buffer/window generator and the activation stage of the synthetic conv datapath.

## Interface
- PIX_W, 8, pixel width (unsigned)
- WGT_W, 8, weight width (unsigned)
- KSIZE, 3, kernel edge; TAPS = KSIZE*KSIZE
- NUM_CH, 4, output channels
- ACC_W, 16, width of each output channel result
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  window valid
- in_ready  out  1  block can accept a window
- pixels_in  in  TAPS*PIX_W  tap t at [t*PIX_W +: PIX_W]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result_out  out  NUM_CH*ACC_W  channel c at [c*ACC_W +: ACC_W]
- wt_we  in  1  weight write strobe
- wt_ch  in  $clog2(NUM_CH)  channel index of write
- wt_tap  in  $clog2(TAPS)  tap index of write
- wt_data  in  WGT_W  weight value
- busy  out  1  high whenever state != IDLE

## Operation
- Weight RAM: NUM_CH x TAPS registers. Reset value w[c][t] = (c+t+2) truncated to WGT_W.
- Weight write: accepted only in IDLE; in ACC/OUT wt_we is ignored (no effect, no queueing). Out-of-range wt_ch/wt_tap ignored.
- FSM states: IDLE, ACC, OUT.
  - IDLE: in_ready=1. On in_valid&&in_ready: latch pixels_in, clear accumulators, tap counter k=0, go ACC.
  - ACC: every cycle, for all c in parallel: acc[c] += pix[k]*w[c][k]; k++. After k=TAPS-1 go OUT.
  - OUT: out_valid=1, result_out stable. On out_ready go IDLE.
- Internal accumulators are PIX_W+WGT_W+$clog2(TAPS) bits; no internal overflow.
- Output reduction to ACC_W per channel is governed by CONV_SATURATE_EN (see Configuration).
- A weight write in the same cycle as a window accept is applied; the new value is used by that window.
- Window latched on accept; pixels_in changes afterward have no effect.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, in_ready=1 after release, out_valid=0, result_out=0, busy=0, accumulators=0, weights reload defaults. Reset mid-ACC or mid-OUT aborts; result discarded.
- in_ready, out_valid, busy are registered-state decodes (no combinational path from in_valid/out_ready).
- Accept at edge E; ACC occupies cycles E+1..E+TAPS; out_valid asserted from edge E+TAPS (TAPS cycles latency, 9 for defaults).
- Minimum window period TAPS+2 cycles (ACC TAPS, OUT >=1, IDLE 1).
- out_ready low: remain in OUT indefinitely, result_out and out_valid stable.
- in_valid while busy: in_ready=0, window not consumed; upstream must hold it.

## Configuration
- CONV_SATURATE_EN defined: each channel result clamps to 2^ACC_W-1 when the internal sum exceeds it.
- Not defined: result is the low ACC_W bits of the internal sum (modulo 2^ACC_W wrap), matching legacy truncation.

## Test plan
- Default weights, all pixels 1, out_ready=1 -> after 9 cycles result_out = 0x0051_0048_003F_0036 (81,72,63,54), out_valid for one cycle.
- Default weights, all pixels 255 -> channels 13770, 16065, 18360, 20655 (ch0..ch3); no saturation in either build.
- Write all ch0 weights 255 in IDLE, pixels 255 -> ch0 = 0xFFFF with CONV_SATURATE_EN, 0xEE09 without; other channels unchanged.
- out_ready held low 5 cycles in OUT -> result_out, out_valid stable; in_ready=0; second window with in_valid held is accepted only after the handshake plus one IDLE cycle.
- wt_we pulsed during ACC (ch1 tap0 = 0) -> ignored; ch1 of current and next window equals default result.
- rst_n low for one cycle at ACC cycle 4 -> out_valid never rises for that window; next cycle busy=0, weights back to defaults, following window of all 1s yields default results.
